// File: rtl/stack_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stack_pkg : shared CPU stack constants and push/pop operation decode
// Revision  : 1.0
// ---------------------------------------------------------------------------
package stack_pkg;

    localparam int          STACK_DATA_W = 16;
    localparam int          STACK_DEPTH  = 16;
    localparam logic [15:0] SP_RESET     = 16'hFFFF;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_e;

    // A push+pop on an empty stack has nothing to replace, so it degrades to a push.
    function automatic stack_op_e decode_op(input logic push, input logic pop,
                                            input logic empty);
        if (push && pop && !empty) return OP_REPLACE;
        else if (push)             return OP_PUSH;
        else if (pop)              return OP_POP;
        else                       return OP_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stack_mem : DEPTH x DATA_W register file, one sync write, one async read
// Revision  : 1.0
// ---------------------------------------------------------------------------
module stack_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/stack_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stack_unit : LIFO stack with architectural stack pointer and sticky errors
// Revision   : 1.0
// ---------------------------------------------------------------------------
module stack_unit
    import stack_pkg::*;
#(
    parameter int               DATA_W    = STACK_DATA_W,
    parameter int               DEPTH     = STACK_DEPTH,
    parameter int               ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] SP_INIT  = ADDR_W'(SP_RESET),
    parameter bit               GROW_DOWN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        top,
    output logic [ADDR_W-1:0]        sp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_underflow;
    stack_op_e         w_op;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [AW-1:0]     w_raddr;
    logic [DATA_W-1:0] w_rdata;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign w_op  = decode_op(push, pop, empty);

    // Read index is always the current top; a replace overwrites that same slot.
    assign w_raddr = AW'(r_count - CW'(1));

    always_comb begin
        w_we    = 1'b0;
        w_waddr = AW'(r_count);
        case (w_op)
            OP_PUSH:    w_we = !full;
            OP_REPLACE: begin
                w_we    = 1'b1;
                w_waddr = w_raddr;
            end
            default:    w_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (w_op)
                OP_PUSH: if (!full)  r_count <= r_count + CW'(1);
                OP_POP:  if (!empty) r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A new error event in the same cycle outranks clr_err.
            r_overflow  <= ((w_op == OP_PUSH) && full)  || (r_overflow  && !clr_err);
            r_underflow <= ((w_op == OP_POP)  && empty) || (r_underflow && !clr_err);
        end
    end

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (w_we),
        .waddr  (w_waddr),
        .wdata  (din),
        .raddr  (w_raddr),
        .rdata  (w_rdata)
    );

    generate
        if (GROW_DOWN) begin : g_sp_down
            assign sp = SP_INIT - ADDR_W'(r_count);
        end else begin : g_sp_up
            assign sp = SP_INIT + ADDR_W'(r_count);
        end
    endgenerate

    assign top       = empty ? '0 : w_rdata;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire
